shift_rx: RTL

Serial-to-parallel receiver that consumes the bit stream and end-of-shift strobe produced by the on-chip `shift` serializer, downstream of that serializer on the Tiny Tapeout pin wrapper. It locks onto word boundaries using the strobe, reassembles each word MSB-first, and flags framing violations. Recovered words are presented with a one-cycle valid pulse, and a frame counter is provided for board-level observation on the 7-segment/uio pins.

---
 rtl/shift_rx.sv | 115 +++++++++++
 1 files changed

// File: rtl/shift_rx.sv
// shift_rx: serial-to-parallel receiver for the on-chip shift serializer.
// Locks on the end-of-shift strobe, rebuilds words MSB-first, flags framing errors.
//
// Parameter:
//   bits    word width (2..16)
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   en      bit-sample enable; sin/eos ignored when low
//   sin     serial data, MSB first
//   eos     end-of-shift strobe, high with the LSB on sin
//   data    last correctly framed word
//   valid   one-cycle pulse when data updates
//   err     sticky framing-error flag, cleared only by rst
//   locked  high while in RECV
//   frames  good-word count, modulo 256
//   chk     XOR checksum of the low byte of good words
// Build option:
//   SHIFT_RX_CHK_EN  builds the checksum register; otherwise chk is tied to 0.

module shift_rx #(
    parameter int bits = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            sin,
    input  logic            eos,
    output logic [bits-1:0] data,
    output logic            valid,
    output logic            err,
    output logic            locked,
    output logic [7:0]      frames,
    output logic [7:0]      chk
);

    localparam int cw = $clog2(bits);
    localparam logic [cw-1:0] last = cw'(bits - 1);

    localparam logic [0:0] SYNC = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    logic [0:0]      state;
    logic [cw-1:0]   cnt;
    logic [bits-1:0] sr;
    logic [bits-1:0] word_new;
    logic            good;

    // Word as it will look once the current bit is shifted in.
    assign word_new = {sr[bits-2:0], sin};
    assign good     = en && (state == RECV) && eos && (cnt == last);
    assign locked   = (state == RECV);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= SYNC;
            cnt    <= '0;
            sr     <= '0;
            data   <= '0;
            valid  <= 1'b0;
            err    <= 1'b0;
            frames <= 8'h00;
        end else begin
            valid <= 1'b0;
            if (en) begin
                unique case (state)
                    SYNC: begin
                        if (eos) begin
                            state <= RECV;
                            cnt   <= '0;
                        end
                    end
                    RECV: begin
                        sr <= word_new;
                        if (good) begin
                            data   <= word_new;
                            valid  <= 1'b1;
                            frames <= frames + 8'h01;
                            cnt    <= '0;
                        end else if (eos || (cnt == last)) begin
                            // Strobe early, or missing at the last bit.
                            err   <= 1'b1;
                            cnt   <= '0;
                            state <= SYNC;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= SYNC;
                endcase
            end
        end
    end

`ifdef SHIFT_RX_CHK_EN
    logic [7:0] chk_q;
    logic [7:0] word_lo;

    // Zero-extends narrow words, drops upper bits of wide ones.
    assign word_lo = 8'(word_new);

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q <= 8'h00;
        end else if (good) begin
            chk_q <= chk_q ^ word_lo;
        end
    end

    assign chk = chk_q;
`else
    assign chk = 8'h00;
`endif

endmodule
